// File: rtl/pe_act_queue_pkg.sv
// Shared types and defaults for the PE activation queue.
package pe_act_queue_pkg;

    localparam int PE_ADDR_WIDTH  = 6;
    localparam int PE_DATA_WIDTH  = 16;
    localparam int PE_QUEUE_DEPTH = 8;

    // Issue counter ceiling.
    localparam logic [7:0] ISSUE_MAX = 8'hFF;

    // Completion FSM states.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } pe_state_e;

    // Classification of the entry sitting at the head of the queue.
    typedef enum logic [1:0] {
        HD_NONE   = 2'd0,
        HD_ACT    = 2'd1,
        HD_ZERO   = 2'd2,
        HD_MARKER = 2'd3
    } head_kind_e;

    // The all-zero entry is the finish marker; zero data with a real address is dropped.
    function automatic head_kind_e classify(input logic empty, input logic addr_zero,
                                            input logic data_zero);
        if (empty)
            return HD_NONE;
        else if (addr_zero && data_zero)
            return HD_MARKER;
        else if (data_zero)
            return HD_ZERO;
        else
            return HD_ACT;
    endfunction

endpackage

// File: rtl/pe_act_queue_fifo.sv
// Show-ahead circular FIFO: storage, wrapping pointers, occupancy and sticky overflow.
module pe_act_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   OCC_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   OCC_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (occupancy == OCC_MAX);
    assign empty = (occupancy == '0);

    // A full queue still takes a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout = mem[rd_ptr];

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && !rd_en)
                occupancy <= occupancy + OCC_ONE;
            else if (rd_en && !wr_en)
                occupancy <= occupancy - OCC_ONE;
            if (push && !wr_en)
                overflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/pe_act_queue.sv
// Activation queue feeding the PE MAC: drops zero activations, detects the finish marker,
// and pulses pop_act once per freed slot for upstream credit return.
module pe_act_queue
    import pe_act_queue_pkg::*;
#(
    parameter int ADDR_W = PE_ADDR_WIDTH,
    parameter int DATA_W = PE_DATA_WIDTH,
    parameter int DEPTH  = PE_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_act,
    input  logic [ADDR_W+DATA_W-1:0]   act,
    input  logic                       pe_start_calc,
    output logic                       pop_act,
    output logic                       mac_valid,
    output logic [ADDR_W-1:0]          mac_addr,
    output logic [DATA_W-1:0]          mac_data,
    input  logic                       mac_ready,
    output logic                       fin_done,
    output logic [7:0]                 issue_cnt,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       queue_full,
    output logic                       queue_empty,
    output logic                       overflow_err
);
    localparam int W = ADDR_W + DATA_W;

    logic [W-1:0]      head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    head_kind_e        kind;
    logic              act_pop;
    logic              marker_pop;
    pe_state_e         state;

    pe_act_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_act),
        .din          (act),
        .pop          (pop_act),
        .dout         (head),
        .occupancy    (occupancy),
        .full         (queue_full),
        .empty        (queue_empty),
        .overflow_err (overflow_err)
    );

    assign head_addr = head[W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];
    assign kind      = classify(queue_empty, head_addr == '0, head_data == '0);

    // ZERO and MARKER heads leave unconditionally; only ACT waits on the MAC.
    assign mac_valid  = (kind == HD_ACT);
    assign act_pop    = mac_valid && mac_ready;
    assign marker_pop = (kind == HD_MARKER);
    assign pop_act    = act_pop || marker_pop || (kind == HD_ZERO);

    assign mac_addr = queue_empty ? '0 : head_addr;
    assign mac_data = queue_empty ? '0 : head_data;

    // Completion FSM; marker removal takes priority over a simultaneous start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            fin_done <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (marker_pop) begin
                        state    <= ST_DONE;
                        fin_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!marker_pop && pe_start_calc) begin
                        state    <= ST_RUN;
                        fin_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    fin_done <= 1'b0;
                end
            endcase
        end
    end

    // Saturating issue counter; a start in the same cycle as an issue counts that issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            issue_cnt <= 8'd0;
        else if (pe_start_calc)
            issue_cnt <= act_pop ? 8'd1 : 8'd0;
        else if (act_pop && issue_cnt != ISSUE_MAX)
            issue_cnt <= issue_cnt + 8'd1;
    end

endmodule
